// File: rtl/capture_pkg.sv
// Shared types and constants for the three-lane sample capture buffer.
package capture_pkg;

  localparam int DEPTH_DEFAULT = 256;
  localparam int ADDR_W        = 8;
  localparam int SAMPLE_W      = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_FULL    = 2'd3
  } state_t;

  // Absolute value of a signed sample; -32768 saturates to 32767.
  function automatic logic [SAMPLE_W-2:0] magnitude(input logic signed [SAMPLE_W-1:0] s);
    logic [SAMPLE_W-1:0] neg;
    neg = -s;
    if (!s[SAMPLE_W-1])
      return s[SAMPLE_W-2:0];
    else if (neg[SAMPLE_W-1])
      return '1;
    else
      return neg[SAMPLE_W-2:0];
  endfunction

endpackage

// File: rtl/capture_ram.sv
// Three-lane sample store: one synchronous write port shared by all lanes,
// one combinational read port for lane 1 and another for lanes 2 and 3.
module capture_ram
  import capture_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                clk,
  input  logic                we,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [SAMPLE_W-1:0] wr_data_1,
  input  logic [SAMPLE_W-1:0] wr_data_2,
  input  logic [SAMPLE_W-1:0] wr_data_3,
  input  logic [ADDR_W-1:0]   rd_addr_a,
  input  logic [ADDR_W-1:0]   rd_addr_b,
  output logic [SAMPLE_W-1:0] rd_data_1,
  output logic [SAMPLE_W-1:0] rd_data_2,
  output logic [SAMPLE_W-1:0] rd_data_3
);

  logic [SAMPLE_W-1:0] lane_1 [DEPTH];
  logic [SAMPLE_W-1:0] lane_2 [DEPTH];
  logic [SAMPLE_W-1:0] lane_3 [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      lane_1[wr_addr] <= wr_data_1;
      lane_2[wr_addr] <= wr_data_2;
      lane_3[wr_addr] <= wr_data_3;
    end
  end

  assign rd_data_1 = lane_1[rd_addr_a];
  assign rd_data_2 = lane_2[rd_addr_b];
  assign rd_data_3 = lane_3[rd_addr_b];

endmodule

// File: rtl/sample_capture_buffer.sv
// Threshold-triggered capture of three microphone lanes for the correlator.
// Define CAPTURE_PRETRIGGER_EN to retain PRE_SAMPLES of history before the trigger.
module sample_capture_buffer
  import capture_pkg::*;
#(
  parameter int DEPTH       = DEPTH_DEFAULT,
  parameter int THRESHOLD   = 1000,
  parameter int PRE_SAMPLES = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                arm,
  input  logic                release_req,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample_1,
  input  logic [SAMPLE_W-1:0] sample_2,
  input  logic [SAMPLE_W-1:0] sample_3,
  input  logic [ADDR_W-1:0]   rd_addr_ref,
  input  logic [ADDR_W-1:0]   rd_addr_other,
  output logic [SAMPLE_W-1:0] rd_data_1,
  output logic [SAMPLE_W-1:0] rd_data_2,
  output logic [SAMPLE_W-1:0] rd_data_3,
  output logic                armed,
  output logic                full
);

`ifdef CAPTURE_PRETRIGGER_EN
  localparam int PRE_KEPT = PRE_SAMPLES;
  localparam logic [ADDR_W-1:0] PRE_ADDR = ADDR_W'(PRE_SAMPLES);
`else
  // With no history retained the whole buffer holds post-trigger data.
  localparam int PRE_KEPT = 0 * PRE_SAMPLES;
`endif
  localparam int POST_COUNT = DEPTH - PRE_KEPT;
  localparam logic [ADDR_W:0]   LAST_POST = (ADDR_W+1)'(POST_COUNT - 1);
  localparam logic [ADDR_W-1:0] ADDR_MASK = ADDR_W'(DEPTH - 1);
  localparam logic [SAMPLE_W-2:0] THR = (SAMPLE_W-1)'(THRESHOLD);

  state_t            state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W:0]   post_cnt;
  logic [ADDR_W-1:0] next_ptr;
  logic              over_thr;
  logic              trigger;
  logic              write_en;
  logic [ADDR_W-1:0] ref_phys;
  logic [ADDR_W-1:0] other_phys;

  assign next_ptr = (wr_ptr + ADDR_W'(1)) & ADDR_MASK;
  assign over_thr = magnitude(sample_1) >= THR;

`ifdef CAPTURE_PRETRIGGER_EN
  logic [ADDR_W:0] pre_cnt;
  assign trigger  = (state == ST_ARMED) && sample_valid && over_thr &&
                    (pre_cnt >= (ADDR_W+1)'(PRE_SAMPLES));
  assign write_en = sample_valid && ((state == ST_ARMED) || (state == ST_CAPTURE));
`else
  assign trigger  = (state == ST_ARMED) && sample_valid && over_thr;
  assign write_en = trigger || (sample_valid && (state == ST_CAPTURE));
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      wr_ptr   <= '0;
      base     <= '0;
      post_cnt <= '0;
`ifdef CAPTURE_PRETRIGGER_EN
      pre_cnt  <= '0;
`endif
    end else begin
      if (write_en)
        wr_ptr <= next_ptr;
      case (state)
        ST_IDLE: begin
          if (arm) begin
            state    <= ST_ARMED;
            wr_ptr   <= '0;
            base     <= '0;
            post_cnt <= '0;
`ifdef CAPTURE_PRETRIGGER_EN
            pre_cnt  <= '0;
`endif
          end
        end
        ST_ARMED: begin
`ifdef CAPTURE_PRETRIGGER_EN
          if (sample_valid && (pre_cnt < (ADDR_W+1)'(PRE_SAMPLES)))
            pre_cnt <= pre_cnt + 1'b1;
`endif
          if (trigger) begin
            post_cnt <= (ADDR_W+1)'(1);
            state    <= (POST_COUNT == 1) ? ST_FULL : ST_CAPTURE;
`ifdef CAPTURE_PRETRIGGER_EN
            // Logical address 0 points at the oldest retained history sample.
            base     <= (wr_ptr - PRE_ADDR) & ADDR_MASK;
`else
            base     <= '0;
`endif
          end
        end
        ST_CAPTURE: begin
          if (sample_valid) begin
            post_cnt <= post_cnt + 1'b1;
            if (post_cnt == LAST_POST)
              state <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (release_req)
            state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign ref_phys   = (base + rd_addr_ref) & ADDR_MASK;
  assign other_phys = (base + rd_addr_other) & ADDR_MASK;

  capture_ram #(
    .DEPTH(DEPTH)
  ) u_ram (
    .clk       (clk),
    .we        (write_en),
    .wr_addr   (wr_ptr),
    .wr_data_1 (sample_1),
    .wr_data_2 (sample_2),
    .wr_data_3 (sample_3),
    .rd_addr_a (ref_phys),
    .rd_addr_b (other_phys),
    .rd_data_1 (rd_data_1),
    .rd_data_2 (rd_data_2),
    .rd_data_3 (rd_data_3)
  );

  assign armed = (state == ST_ARMED);
  assign full  = (state == ST_FULL);

endmodule

// File: tb/tb_sample_capture_buffer.sv
// Directed self-checking bench for sample_capture_buffer (both build variants).
module tb_sample_capture_buffer;

`ifdef CAPTURE_PRETRIGGER_EN
  localparam int PRE = 32;
`else
  localparam int PRE = 0;
`endif
  localparam int POST = 256 - PRE;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        arm, release_req, sample_valid;
  logic [15:0] sample_1, sample_2, sample_3;
  logic [7:0]  rd_addr_ref, rd_addr_other;
  logic [15:0] rd_data_1, rd_data_2, rd_data_3;
  logic        armed, full;

  logic        b_arm, b_release, b_valid;
  logic [15:0] b_s1, b_s2, b_s3;
  logic [7:0]  b_rd_ref, b_rd_other;
  logic [15:0] b_rd_1, b_rd_2, b_rd_3;
  logic        b_armed, b_full;

  int checks = 0;
  int errors = 0;

  sample_capture_buffer dut (
    .clk(clk), .reset_n(reset_n), .arm(arm), .release_req(release_req),
    .sample_valid(sample_valid), .sample_1(sample_1), .sample_2(sample_2),
    .sample_3(sample_3), .rd_addr_ref(rd_addr_ref), .rd_addr_other(rd_addr_other),
    .rd_data_1(rd_data_1), .rd_data_2(rd_data_2), .rd_data_3(rd_data_3),
    .armed(armed), .full(full)
  );

  sample_capture_buffer #(.THRESHOLD(32767)) dut_max (
    .clk(clk), .reset_n(reset_n), .arm(b_arm), .release_req(b_release),
    .sample_valid(b_valid), .sample_1(b_s1), .sample_2(b_s2),
    .sample_3(b_s3), .rd_addr_ref(b_rd_ref), .rd_addr_other(b_rd_other),
    .rd_data_1(b_rd_1), .rd_data_2(b_rd_2), .rd_data_3(b_rd_3),
    .armed(b_armed), .full(b_full)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL timeout simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic v, input int a, input int b, input int c);
    sample_valid = v;
    sample_1 = 16'(a);
    sample_2 = 16'(b);
    sample_3 = 16'(c);
  endtask

  task automatic bput(input logic v, input int a, input int b, input int c);
    b_valid = v;
    b_s1 = 16'(a);
    b_s2 = 16'(b);
    b_s3 = 16'(c);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    arm = 1'b1; release_req = 1'b0; b_arm = 1'b1; b_release = 1'b0;
    put(0, 0, 0, 0); bput(0, 0, 0, 0);
    rd_addr_ref = '0; rd_addr_other = '0; b_rd_ref = '0; b_rd_other = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (armed !== 1'b0) begin errors++; $display("[TB] FAIL reset_armed got %b expected 0", armed); end
    checks++; if (full !== 1'b0) begin errors++; $display("[TB] FAIL reset_full got %b expected 0", full); end
    checks++; if (b_armed !== 1'b0) begin errors++; $display("[TB] FAIL reset_b_armed got %b expected 0", b_armed); end
    arm = 1'b0; b_arm = 1'b0;
    reset_n = 1'b1;
    tick();
    checks++; if (armed !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_idle got %b expected 0", armed); end
  endtask

  task automatic test_ramp();
    int v;
    int exp;
    arm = 1'b1; tick(); arm = 1'b0;
    checks++; if (armed !== 1'b1) begin errors++; $display("[TB] FAIL ramp_armed got %b expected 1", armed); end
    for (int i = 0; i <= 100 + POST - 1; i++) begin
      v = i * 10;
      put(1, v, v + 1, v + 2);
      tick();
      if (i == 99) begin
        checks++; if (armed !== 1'b1) begin errors++; $display("[TB] FAIL ramp_below_thr got %b expected 1", armed); end
      end
      if (i == 100) begin
        checks++; if (armed !== 1'b0) begin errors++; $display("[TB] FAIL ramp_trigger got %b expected 0", armed); end
      end
      if (i == 100 + POST - 2) begin
        checks++; if (full !== 1'b0) begin errors++; $display("[TB] FAIL ramp_early_full got %b expected 0", full); end
      end
    end
    put(0, 0, 0, 0);
    checks++; if (full !== 1'b1) begin errors++; $display("[TB] FAIL ramp_full got %b expected 1", full); end
    rd_addr_ref = 8'd0; #1;
    exp = 1000 - PRE * 10;
    checks++; if (rd_data_1 !== 16'(exp)) begin errors++; $display("[TB] FAIL ramp_addr0 got %0d expected %0d", rd_data_1, exp); end
    rd_addr_ref = 8'd255; #1;
    exp = 1000 + (POST - 1) * 10;
    checks++; if (rd_data_1 !== 16'(exp)) begin errors++; $display("[TB] FAIL ramp_addr255 got %0d expected %0d", rd_data_1, exp); end
    rd_addr_ref = 8'(PRE); #1;
    checks++; if (rd_data_1 !== 16'd1000) begin errors++; $display("[TB] FAIL ramp_trig_addr got %0d expected 1000", rd_data_1); end
    rd_addr_other = 8'd5; #1;
    exp = 1000 + (5 - PRE) * 10;
    checks++; if (rd_data_2 !== 16'(exp + 1)) begin errors++; $display("[TB] FAIL ramp_lane2 got %0d expected %0d", rd_data_2, exp + 1); end
    checks++; if (rd_data_3 !== 16'(exp + 2)) begin errors++; $display("[TB] FAIL ramp_lane3 got %0d expected %0d", rd_data_3, exp + 2); end
  endtask

  task automatic test_full_hold();
    int exp;
    rd_addr_ref = 8'(PRE); rd_addr_other = 8'd5;
    exp = 1000 + (5 - PRE) * 10 + 1;
    for (int i = 0; i < 5; i++) begin
      put(1, 7, 7, 7);
      arm = (i == 2);
      tick();
    end
    arm = 1'b0; put(0, 0, 0, 0);
    checks++; if (full !== 1'b1) begin errors++; $display("[TB] FAIL hold_full got %b expected 1", full); end
    checks++; if (rd_data_1 !== 16'd1000) begin errors++; $display("[TB] FAIL hold_lane1 got %0d expected 1000", rd_data_1); end
    checks++; if (rd_data_2 !== 16'(exp)) begin errors++; $display("[TB] FAIL hold_lane2 got %0d expected %0d", rd_data_2, exp); end
    arm = 1'b1; release_req = 1'b1; tick(); arm = 1'b0; release_req = 1'b0;
    checks++; if (full !== 1'b0) begin errors++; $display("[TB] FAIL arm_rel_full got %b expected 0", full); end
    checks++; if (armed !== 1'b0) begin errors++; $display("[TB] FAIL arm_rel_armed got %b expected 0", armed); end
    tick();
    checks++; if (armed !== 1'b0) begin errors++; $display("[TB] FAIL arm_rel_idle got %b expected 0", armed); end
    arm = 1'b1; tick(); arm = 1'b0;
    release_req = 1'b1; tick(); release_req = 1'b0;
    checks++; if (armed !== 1'b1) begin errors++; $display("[TB] FAIL release_in_armed got %b expected 1", armed); end
  endtask

  task automatic test_saturation_gaps();
    b_arm = 1'b1; tick(); b_arm = 1'b0;
    for (int i = 0; i < PRE; i++) begin bput(1, 0, 0, 0); tick(); end
    bput(1, 32766, 0, 0); tick();
    checks++; if (b_armed !== 1'b1) begin errors++; $display("[TB] FAIL sat_below got %b expected 1", b_armed); end
    bput(1, 16'h8000, 0, 0); tick();
    checks++; if (b_armed !== 1'b0) begin errors++; $display("[TB] FAIL sat_trigger got %b expected 0", b_armed); end
    for (int i = 1; i <= POST - 1; i++) begin
      if (i % 3 == 0) begin
        bput(0, 16'h5555, 16'h5555, 16'h5555); tick(); tick();
      end
      bput(1, i, i + 100, i + 200); tick();
      if (i == POST - 2) begin
        checks++; if (b_full !== 1'b0) begin errors++; $display("[TB] FAIL gap_early_full got %b expected 0", b_full); end
      end
    end
    bput(0, 0, 0, 0);
    checks++; if (b_full !== 1'b1) begin errors++; $display("[TB] FAIL gap_full got %b expected 1", b_full); end
    b_rd_ref = 8'(PRE); #1;
    checks++; if (b_rd_1 !== 16'h8000) begin errors++; $display("[TB] FAIL sat_stored got %h expected 8000", b_rd_1); end
    b_rd_ref = 8'(PRE + 3); #1;
    checks++; if (b_rd_1 !== 16'd3) begin errors++; $display("[TB] FAIL gap_no_write got %0d expected 3", b_rd_1); end
    b_rd_ref = 8'd255; #1;
    checks++; if (b_rd_1 !== 16'(POST - 1)) begin errors++; $display("[TB] FAIL gap_last got %0d expected %0d", b_rd_1, POST - 1); end
    b_rd_other = 8'(PRE + 2); #1;
    checks++; if (b_rd_3 !== 16'd202) begin errors++; $display("[TB] FAIL gap_lane3 got %0d expected 202", b_rd_3); end
  endtask

  task automatic test_reset_mid_capture();
    for (int i = 0; i < PRE; i++) begin put(1, 5, 0, 0); tick(); end
    put(1, 1000, 0, 0); tick();
    for (int i = 0; i < 4; i++) begin put(1, 20, 0, 0); tick(); end
    put(0, 0, 0, 0);
    #1 reset_n = 1'b0;
    #1;
    checks++; if (full !== 1'b0) begin errors++; $display("[TB] FAIL async_rst_full got %b expected 0", full); end
    checks++; if (armed !== 1'b0) begin errors++; $display("[TB] FAIL async_rst_armed got %b expected 0", armed); end
    checks++; if (b_full !== 1'b0) begin errors++; $display("[TB] FAIL async_rst_b_full got %b expected 0", b_full); end
    @(posedge clk); #2 reset_n = 1'b1;
    tick();
    checks++; if (armed !== 1'b0) begin errors++; $display("[TB] FAIL rst_idle got %b expected 0", armed); end
    arm = 1'b1; tick(); arm = 1'b0;
    checks++; if (armed !== 1'b1) begin errors++; $display("[TB] FAIL rearm got %b expected 1", armed); end
    for (int i = 0; i < PRE; i++) begin put(1, 3, 0, 0); tick(); end
    put(1, 5000, 0, 0); tick();
    for (int i = 1; i <= POST - 1; i++) begin
      put(1, 100 + i, 0, 0); tick();
      if (i == POST - 2) begin
        checks++; if (full !== 1'b0) begin errors++; $display("[TB] FAIL restart_early_full got %b expected 0", full); end
      end
    end
    put(0, 0, 0, 0);
    checks++; if (full !== 1'b1) begin errors++; $display("[TB] FAIL restart_full got %b expected 1", full); end
    rd_addr_ref = 8'(PRE); #1;
    checks++; if (rd_data_1 !== 16'd5000) begin errors++; $display("[TB] FAIL restart_trig got %0d expected 5000", rd_data_1); end
    rd_addr_ref = 8'd255; #1;
    checks++; if (rd_data_1 !== 16'(100 + POST - 1)) begin errors++; $display("[TB] FAIL restart_last got %0d expected %0d", rd_data_1, 100 + POST - 1); end
    release_req = 1'b1; tick(); release_req = 1'b0;
  endtask

`ifdef CAPTURE_PRETRIGGER_EN
  task automatic test_pretrigger();
    arm = 1'b1; tick(); arm = 1'b0;
    for (int k = 0; k < 40; k++) begin put(1, k, 0, 0); tick(); end
    put(1, 1000, 0, 0); tick();
    for (int i = 1; i <= POST - 1; i++) begin put(1, 50, 0, 0); tick(); end
    put(0, 0, 0, 0);
    checks++; if (full !== 1'b1) begin errors++; $display("[TB] FAIL pre_full got %b expected 1", full); end
    rd_addr_ref = 8'd31; #1;
    checks++; if (rd_data_1 !== 16'd39) begin errors++; $display("[TB] FAIL pre_addr31 got %0d expected 39", rd_data_1); end
    rd_addr_ref = 8'd32; #1;
    checks++; if (rd_data_1 !== 16'd1000) begin errors++; $display("[TB] FAIL pre_addr32 got %0d expected 1000", rd_data_1); end
    rd_addr_ref = 8'd0; #1;
    checks++; if (rd_data_1 !== 16'd8) begin errors++; $display("[TB] FAIL pre_addr0 got %0d expected 8", rd_data_1); end
    release_req = 1'b1; tick(); release_req = 1'b0;
    arm = 1'b1; tick(); arm = 1'b0;
    for (int i = 1; i <= 9; i++) begin put(1, 0, 0, 0); tick(); end
    put(1, 1500, 0, 0); tick();
    checks++; if (armed !== 1'b1) begin errors++; $display("[TB] FAIL pre_early_cross got %b expected 1", armed); end
    for (int i = 11; i <= 32; i++) begin put(1, 0, 0, 0); tick(); end
    put(1, 1500, 0, 0); tick();
    checks++; if (armed !== 1'b0) begin errors++; $display("[TB] FAIL pre_late_cross got %b expected 0", armed); end
    for (int i = 1; i <= POST - 1; i++) begin put(1, 0, 0, 0); tick(); end
    put(0, 0, 0, 0);
    checks++; if (full !== 1'b1) begin errors++; $display("[TB] FAIL pre_cross_full got %b expected 1", full); end
  endtask
`endif

  initial begin
    test_reset();
    test_ramp();
    test_full_hold();
    test_saturation_gaps();
    test_reset_mid_capture();
`ifdef CAPTURE_PRETRIGGER_EN
    test_pretrigger();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
